// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the fetch->decode instruction queue.
// Project-wide widths are macros so the rest of the core can override them.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef IQ_DEPTH
`define IQ_DEPTH 4
`endif
`ifndef NOP_INSTR
`define NOP_INSTR 32'h00000000
`endif

package instr_queue_pkg;
   localparam int WORD_W   = `WORD_WIDTH;
   localparam int IQ_DEPTH = `IQ_DEPTH;
   localparam logic [WORD_W-1:0] NOP_INSTR = `NOP_INSTR;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } iq_entry_t;
endpackage

// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// master = the fetch+decode side driving the queue, slave = the queue itself.
interface instr_queue_if
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
);
   logic              validF;
   logic [WORD_W-1:0] pcF;
   logic [WORD_W-1:0] instrF;
   logic              stallF;
   logic              stallD;
   logic              flushD;
   logic              validD;
   logic [WORD_W-1:0] pcD;
   logic [WORD_W-1:0] instrD;
   logic [PTR_W:0]    count;

   modport master (
      output validF, pcF, instrF, stallD, flushD,
      input  stallF, validD, pcD, instrD, count
   );

   modport slave (
      input  validF, pcF, instrF, stallD, flushD,
      output stallF, validD, pcD, instrD, count
   );
endinterface

// File: rtl/instr_queue.sv
// Show-ahead circular buffer between fetch and decode. stallF depends only on
// registered occupancy, so decode's stall never reaches fetch combinationally.
module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst,
   instr_queue_if.slave  bus
);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   iq_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full, empty, push, pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = bus.validF && !full;
   assign pop   = !empty && !bus.stallD;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flushD) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{pc: bus.pcF, instr: bus.instrF};
   end

   assign bus.stallF = full;
   assign bus.validD = !empty;
   assign bus.count  = count_q;
   assign bus.pcD    = empty ? '0        : mem_q[rd_ptr_q].pc;
   assign bus.instrD = empty ? NOP_INSTR : mem_q[rd_ptr_q].instr;
endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue sitting between the fetch stage and decode: it accepts one {pc, instr} pair per cycle from fetch, buffers up to DEPTH entries, and presents the oldest entry to decode with a valid/stall handshake. When the queue is full it back-pressures fetch through stallF, which holds the PC. A resolved branch or jump flushes all buffered entries through flushD. The block is the consuming end of the fetch interface: fetch writes, decode reads.

## Interface
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- PTR_W, 2: pointer width, log2(DEPTH).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- validF  in  1  fetch presents a valid instruction this cycle.
- pcF  in  `WORD_WIDTH  PC of the fetched instruction.
- instrF  in  `WORD_WIDTH  fetched instruction word.
- stallF  out  1  queue full; fetch must hold its PC.
- stallD  in  1  decode cannot accept the head entry this cycle.
- flushD  in  1  discard all queued entries (redirect).
- validD  out  1  head entry valid.
- pcD  out  `WORD_WIDTH  head entry PC.
- instrD  out  `WORD_WIDTH  head entry instruction.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH {pc, instr} entries, with a write pointer wr_ptr, a read pointer rd_ptr and a count register.
- full = (count == DEPTH); empty = (count == 0).
- stallF = full. It is driven from registered state only, with no combinational path from stallD.
- validD = !empty.
- The queue is show-ahead: pcD/instrD come combinationally from entry rd_ptr when validD = 1. They are forced to 0 (`NOP_INSTR`) when empty.
- push = validF && !full.
  - A push writes {pcF, instrF} at wr_ptr, then wr_ptr ← wr_ptr+1 mod DEPTH.
- pop = validD && !stallD.
  - A pop advances rd_ptr ← rd_ptr+1 mod DEPTH.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Full with a pop in the same cycle: the push is still refused, because stallF reflects the start-of-cycle state. Fetch retries the next cycle. There is no full-bypass.
- Empty with a push: there is no bypass to decode. The entry becomes visible the following cycle.
- flushD = 1: wr_ptr, rd_ptr and count are cleared to 0. Any same-cycle push and pop are discarded. Flush has priority over push and pop.
- Reset (rst = 0 at a rising edge) has priority over flush. Storage contents are don't-care.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0.
  - validD = 0, stallF = 0.
  - pcD = instrD = 0.
- Reset asserted mid-operation discards every queued entry, identically to a flush.

## Timing
- Latency: a push at edge N is visible on pcD/instrD/validD after edge N, i.e. in cycle N+1.
- Sustained throughput is one entry per cycle when not full and stallD = 0. After the first fill cycle the queue stays at count = 1 with push and pop every cycle.
- stallF rises in the cycle after the push that makes count = DEPTH. It falls in the cycle after the first pop from full.
- After a flush at edge N: validD = 0 and stallF = 0 in cycle N+1. A push in cycle N+1 is visible in cycle N+2.
- Pointer wrap: DEPTH−1 → 0 with no bubble.

## Structure
- Add `IQ_DEPTH (4) and `NOP_INSTR (32'h00000000) to defines.vh, alongside `WORD_WIDTH. DEPTH defaults to `IQ_DEPTH.
- Single module with an inline storage array; no sub-module is needed.
- Instantiated by the top level between fetch and decode. The top level wires fetch's pcF/instrF/stallF to the queue, and the hazard unit's redirect to flushD.

## Test plan
- Reset: hold rst = 0 for 2 cycles with validF = 1 → count = 0, validD = 0, stallF = 0, pcD = instrD = 0.
- Fill: stallD = 1; push pc 0x00, 0x04, 0x08, 0x0C → count = 4 and stallF = 1 after the 4th edge. A 5th push (pc 0x10) is refused and count stays 4.
- Drain in order: from full, stallD = 0 and validF = 0 → pcD reads 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then validD = 0 with count = 0.
- Streaming with wrap: validF = 1 and stallD = 0 for 10 cycles with pc incrementing by 4 from 0x00 → pcD lags pcF by one cycle, count stays 1, and there are no gaps across the pointer wrap.
- Full with simultaneous pop: at count = 4, pop and present pc 0x10 in the same cycle → 0x10 is not accepted (count = 3). It is accepted on the retry next cycle (count = 4).
- Flush priority: at count = 2, assert flushD with validF = 1 (pc 0x40) and stallD = 0 → next cycle count = 0, validD = 0. Then push 0x80 → pcD = 0x80 one cycle later. Assert rst = 0 together with flushD → reset values result.
